// File: rtl/button_pkg.sv
// Shared types for the push-button pulse generator.
// Holds the debounce FSM state encoding and a small sizing helper.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Async active-low reset clears both stages to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced push-button to single-cycle enable pulse for the up counter.
// Define BUTTON_REPEAT_EN to emit auto-repeat pulses while the button is held.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_CYCLES   = 50000,
    parameter int CNT_W           =
        $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic en,
    output logic btn_state
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             w_s;
    btn_state_e       w_next;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_pulse;

    btn_state_e       r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_en;
    logic             r_btn_state;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_s)
    );

    // Timer is cleared on every state entry, so it only ever counts within one state.
    always_comb begin
        w_next      = r_state;
        w_timer_nxt = r_timer;
        w_pulse     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_next      = PRESS_WAIT;
                    w_timer_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_next      = IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == DEB_LAST) begin
                    w_next      = HELD;
                    w_timer_nxt = '0;
                    w_pulse     = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            HELD: begin
                if (!w_s) begin
                    w_next      = RELEASE_WAIT;
                    w_timer_nxt = '0;
                end
`ifdef BUTTON_REPEAT_EN
                else if (r_timer == REP_LAST) begin
                    w_pulse     = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_next      = HELD;
                    w_timer_nxt = '0;
                end else if (r_timer == DEB_LAST) begin
                    w_next      = IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_next      = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_en        <= 1'b0;
            r_btn_state <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_timer_nxt;
            r_en        <= w_pulse;
            r_btn_state <= (w_next == HELD) || (w_next == RELEASE_WAIT);
        end
    end

    assign en        = r_en;
    assign btn_state = r_btn_state;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Randomised, model-checked bench for button_pulse_gen (D=4, R=8).
// Honours BUTTON_REPEAT_EN when the design is built with it.
module tb_button_pulse_gen;

    localparam int D = 4;
    localparam int R = 8;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic btn_in;
    logic en;
    logic btn_state;
    logic [7:0] up_cnt;

    int n_checks;
    int n_pass;

    // Reference model: synced-sample history, run length, hold time.
    bit m_s1, m_s2;
    bit m_level;
    int m_run;
    int m_hcnt;
    bit m_en;
    int m_pulses;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .btn_in    (btn_in),
        .en        (en),
        .btn_state (btn_state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) up_cnt <= 8'd0;
        else if (en) up_cnt <= up_cnt + 8'd1;
    end

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0;
        m_run = 0; m_hcnt = 0; m_en = 0;
    endtask

    // A level change is accepted after D+1 consecutive opposite synced samples.
    task automatic tick();
        bit s;
        @(posedge clk);
        if (rst_n) begin
            s = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_en = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = s;
                    m_run = 0;
                    m_hcnt = 0;
                    if (s) begin
                        m_en = 1;
                        m_pulses++;
                    end
                end
            end else begin
                if (m_level && m_run > 0) begin
                    m_hcnt = 0;
                end else if (m_level && REP) begin
                    if (m_hcnt == R - 1) begin
                        m_en = 1;
                        m_pulses++;
                        m_hcnt = 0;
                    end else begin
                        m_hcnt++;
                    end
                end
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if (en !== 1'b0)
                $display("FAIL reset_en cyc=%0d got=%b exp=0", i, en);
            else n_pass++;
            n_checks++;
            if (btn_state !== 1'b0)
                $display("FAIL reset_state cyc=%0d got=%b exp=0", i, btn_state);
            else n_pass++;
        end
    endtask

    task automatic test_press();
        int first_en, first_st, pulses;
        first_en = -1; first_st = -1; pulses = 0;
        btn_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (en === 1'b1) pulses++;
            if (en === 1'b1 && first_en < 0) first_en = k;
            if (btn_state === 1'b1 && first_st < 0) first_st = k;
            n_checks++;
            if (en !== m_en)
                $display("FAIL press_en k=%0d got=%b exp=%b", k, en, m_en);
            else n_pass++;
        end
        n_checks++;
        if (first_en !== 7)
            $display("FAIL press_latency got=%0d exp=7", first_en);
        else n_pass++;
        n_checks++;
        if (first_st !== 7)
            $display("FAIL press_state_edge got=%0d exp=7", first_st);
        else n_pass++;
        n_checks++;
        if (pulses !== (REP ? 2 : 1))
            $display("FAIL press_pulses got=%0d exp=%0d", pulses, REP ? 2 : 1);
        else n_pass++;
        btn_in = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        n_checks++;
        if (btn_state !== 1'b0)
            $display("FAIL press_release got=%b exp=0", btn_state);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int seen_en, seen_st;
        seen_en = 0; seen_st = 0;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 3; j++) begin
                btn_in = (j < 2);
                tick();
                if (en === 1'b1) seen_en++;
                if (btn_state === 1'b1) seen_st++;
            end
        end
        btn_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (en === 1'b1) seen_en++;
            if (btn_state === 1'b1) seen_st++;
        end
        n_checks++;
        if (seen_en !== 0)
            $display("FAIL bounce_en got=%0d exp=0", seen_en);
        else n_pass++;
        n_checks++;
        if (seen_st !== 0)
            $display("FAIL bounce_state got=%0d exp=0", seen_st);
        else n_pass++;
    endtask

    task automatic test_release_glitch();
        int pulses, fall_k;
        btn_in = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        pulses = 0; fall_k = -1;
        for (int k = 1; k <= 16; k++) begin
            btn_in = (k == 2);
            tick();
            if (en === 1'b1) pulses++;
            if (btn_state === 1'b0 && fall_k < 0) fall_k = k;
            n_checks++;
            if (btn_state !== m_level)
                $display("FAIL glitch_state k=%0d got=%b exp=%b",
                         k, btn_state, m_level);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 0)
            $display("FAIL glitch_pulses got=%0d exp=0", pulses);
        else n_pass++;
        // Glitch sampled at k=2 is seen by the FSM at k=4; 5 low samples follow.
        n_checks++;
        if (fall_k !== 9)
            $display("FAIL glitch_fall got=%0d exp=9", fall_k);
        else n_pass++;
    endtask

    task automatic test_reset_midpress();
        int first_en, pulses;
        btn_in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        #4 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (en !== 1'b0 || btn_state !== 1'b0)
            $display("FAIL midrst_immediate en=%b st=%b exp=0", en, btn_state);
        else n_pass++;
        tick();
        tick();
        #4 rst_n = 1'b1;
        first_en = -1; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (en === 1'b1) pulses++;
            if (en === 1'b1 && first_en < 0) first_en = k;
            n_checks++;
            if (en !== m_en)
                $display("FAIL midrst_en k=%0d got=%b exp=%b", k, en, m_en);
            else n_pass++;
        end
        n_checks++;
        if (first_en !== 7 || pulses !== 1)
            $display("FAIL midrst_pulse edge=%0d n=%0d exp=7/1", first_en, pulses);
        else n_pass++;
        btn_in = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_repeat();
        logic [7:0] c0, dc;
        int bad;
        c0 = up_cnt; bad = 0;
        btn_in = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (en !== ((k >= 7) && (REP ? ((k - 7) % R == 0) : (k == 7))))
                bad++;
        end
        btn_in = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        n_checks++;
        if (bad !== 0)
            $display("FAIL repeat_pattern bad_cycles=%0d exp=0", bad);
        else n_pass++;
        dc = up_cnt - c0;
        n_checks++;
        if (dc !== (REP ? 8'd5 : 8'd1))
            $display("FAIL repeat_count got=%0d exp=%0d", dc, REP ? 5 : 1);
        else n_pass++;
    endtask

    task automatic test_random();
        int p0;
        logic [7:0] c0, dc;
        bit lvl;
        int len;
        p0 = m_pulses; c0 = up_cnt;
        for (int seg = 0; seg < 40; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? 12 : $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                btn_in = lvl;
                tick();
                n_checks++;
                if (en !== m_en)
                    $display("FAIL rand_en seg=%0d got=%b exp=%b", seg, en, m_en);
                else n_pass++;
                n_checks++;
                if (btn_state !== m_level)
                    $display("FAIL rand_state seg=%0d got=%b exp=%b",
                             seg, btn_state, m_level);
                else n_pass++;
            end
        end
        dc = up_cnt - c0;
        n_checks++;
        if (dc !== 8'(m_pulses - p0))
            $display("FAIL rand_count got=%0d exp=%0d", dc, m_pulses - p0);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        m_pulses = 0;
        model_reset();
        rst_n = 1'b0;
        btn_in = 1'b0;
        #15 rst_n = 1'b1;
        test_reset();
        test_press();
        test_bounce();
        test_release_glitch();
        test_reset_midpress();
        test_repeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
